sdfa_snn_top: RTL and testbench

- Top level of a single-layer spiking/accumulate digit classifier for 28x28 8-bit images (MNIST format).
- Serially loads three configuration strings, then accepts each image as 98 64-bit words.
- Accumulates thresholded pixels against an internal preloaded signed weight memory into 10 class accumulators.
- Emits the winning class as a 10-cycle serial one-hot spike train.

---
 rtl/sdfa_snn_top.sv | 215 +++++++++++++++++++++
 tb/tb_sdfa_snn_top.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sdfa_snn_top.sv
// Single-layer spiking/accumulate digit classifier: serial config load, 98-word image
// accumulation against a preloaded signed weight memory, one-hot serial class output.

module sdfa_weight_sram #(
   parameter int unsigned ROWS  = 98,
   parameter int unsigned WIDTH = 320,
   parameter int unsigned AW    = 7
) (
   input  logic             clk,
   input  logic [AW-1:0]    ADDR_WRITE,
   input  logic             WE,
   input  logic [WIDTH-1:0] DIN,
   input  logic [AW-1:0]    i_addr_rd,
   output logic [WIDTH-1:0] o_dout_c
);
   logic [WIDTH-1:0] r_mem [ROWS];

   always_ff @(posedge clk) begin
      if (!WE) r_mem[ADDR_WRITE] <= DIN;
   end

   assign o_dout_c = r_mem[i_addr_rd];
endmodule

module sdfa_snn_top #(
   parameter int unsigned N_WORDS = 98,
   parameter int unsigned N_CLASS = 10,
   parameter int unsigned W_BITS  = 4,
   parameter int unsigned ACC_W   = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [63:0] data_in,
   input  logic        pixel_valid,
   input  logic        train,
   input  logic        set_number,
   input  logic        set_valid,
   input  logic        master_inf_valid,
   input  logic        master_in,
   input  logic        block_inf_valid,
   input  logic        block_in,
   output logic        image_req,
   output logic        set_up_req,
   output logic        result_spike,
   output logic        result_spike_valid
);
   localparam int unsigned N_PIX = 8;
   localparam int unsigned ROW_W = N_PIX * N_CLASS * W_BITS;
   localparam int unsigned AW    = $clog2(N_WORDS);
   localparam int unsigned KW    = $clog2(N_CLASS);
   localparam int unsigned SET_N = 12;
   localparam int unsigned MST_N = 255;
   localparam int unsigned BLK_N = 171;
   localparam int unsigned SCW   = $clog2(SET_N + 1);
   localparam int unsigned MCW   = $clog2(MST_N + 1);
   localparam int unsigned BCW   = $clog2(BLK_N + 1);

   typedef enum logic [2:0] {S_CFG, S_IDLE, S_LOAD, S_DECIDE, S_OUT} state_t;

   state_t                   r_state, w_state_nxt;
   logic [SET_N-1:0]         r_set_cfg;
   logic [MST_N-1:0]         r_mst_cfg;
   logic [BLK_N-1:0]         r_blk_cfg;
   logic [SCW-1:0]           r_set_cnt;
   logic [MCW-1:0]           r_mst_cnt;
   logic [BCW-1:0]           r_blk_cnt;
   logic [AW-1:0]            r_wcnt;
   logic signed [ACC_W-1:0]  r_acc [N_CLASS];
   logic [KW-1:0]            r_winner, r_k;
   logic                     r_image_req, r_set_up_req, r_spike, r_valid;

   logic                     w_set_full_n, w_mst_full_n, w_blk_full_n;
   logic                     w_consume, w_first, w_valid_nxt, w_spike_nxt;
   logic [ROW_W-1:0]         w_row;
   logic [W_BITS-1:0]        w_wt;
   logic signed [ACC_W-1:0]  w_contrib [N_CLASS];
   logic signed [ACC_W-1:0]  w_best;
   logic [KW-1:0]            w_winner;
   logic [7:0]               w_thr;
   logic                     w_unused_ok;

   assign w_thr       = r_set_cfg[7:0];
   assign w_unused_ok = ^{train, r_set_cfg[SET_N-1:8], r_mst_cfg, r_blk_cfg};

   // Counter values after this edge: lets set_up_req/image_req register on the loading edge
   assign w_set_full_n = (r_set_cnt == SCW'(SET_N)) || (set_valid && (r_set_cnt == SCW'(SET_N - 1)));
   assign w_mst_full_n = (r_mst_cnt == MCW'(MST_N)) || (master_inf_valid && (r_mst_cnt == MCW'(MST_N - 1)));
   assign w_blk_full_n = (r_blk_cnt == BCW'(BLK_N)) || (block_inf_valid && (r_blk_cnt == BCW'(BLK_N - 1)));

   sdfa_weight_sram #(.ROWS(N_WORDS), .WIDTH(ROW_W), .AW(AW)) u_weight_sram (
      .clk        (clk),
      .ADDR_WRITE (AW'(0)),
      .WE         (1'b1),
      .DIN        (ROW_W'(0)),
      .i_addr_rd  (r_wcnt),
      .o_dout_c   (w_row)
   );

   // Serial LSB-first config capture with saturating counters
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_set_cfg <= '0;
         r_mst_cfg <= '0;
         r_blk_cfg <= '0;
         r_set_cnt <= '0;
         r_mst_cnt <= '0;
         r_blk_cnt <= '0;
      end else begin
         if (set_valid && (r_set_cnt != SCW'(SET_N))) begin
            r_set_cfg[r_set_cnt] <= set_number;
            r_set_cnt            <= r_set_cnt + SCW'(1);
         end
         if (master_inf_valid && (r_mst_cnt != MCW'(MST_N))) begin
            r_mst_cfg[r_mst_cnt] <= master_in;
            r_mst_cnt            <= r_mst_cnt + MCW'(1);
         end
         if (block_inf_valid && (r_blk_cnt != BCW'(BLK_N))) begin
            r_blk_cfg[r_blk_cnt] <= block_in;
            r_blk_cnt            <= r_blk_cnt + BCW'(1);
         end
      end
   end

   // Per-class contribution of the current word: sum of weights of pixels at/above threshold
   always_comb begin
      w_wt = '0;
      for (int c = 0; c < int'(N_CLASS); c++) begin
         w_contrib[c] = '0;
         for (int p = 0; p < int'(N_PIX); p++) begin
            w_wt = w_row[(p * int'(N_CLASS) + c) * int'(W_BITS) +: W_BITS];
            if (data_in[8*p +: 8] >= w_thr)
               w_contrib[c] = w_contrib[c] + {{(ACC_W-W_BITS){w_wt[W_BITS-1]}}, w_wt};
         end
      end
   end

   // Signed argmax; strict compare keeps the lowest index on ties
   always_comb begin
      w_best   = r_acc[0];
      w_winner = '0;
      for (int c = 1; c < int'(N_CLASS); c++) begin
         if (r_acc[c] > w_best) begin
            w_best   = r_acc[c];
            w_winner = KW'(c);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_consume   = 1'b0;
      w_first     = 1'b0;
      w_valid_nxt = 1'b0;
      w_spike_nxt = 1'b0;
      case (r_state)
         S_CFG:    if (w_set_full_n) w_state_nxt = S_IDLE;
         S_IDLE: begin
            if (pixel_valid) begin
               w_consume   = 1'b1;
               w_first     = 1'b1;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (pixel_valid) begin
               w_consume = 1'b1;
               if (r_wcnt == AW'(N_WORDS - 1)) w_state_nxt = S_DECIDE;
            end
         end
         S_DECIDE: w_state_nxt = S_OUT;
         S_OUT: begin
            w_valid_nxt = 1'b1;
            w_spike_nxt = (r_k == r_winner);
            if (r_k == KW'(N_CLASS - 1)) w_state_nxt = S_IDLE;
         end
         default:  w_state_nxt = S_CFG;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         r_state      <= S_CFG;
         r_wcnt       <= '0;
         r_winner     <= '0;
         r_k          <= '0;
         r_image_req  <= 1'b0;
         r_set_up_req <= 1'b1;
         r_valid      <= 1'b0;
         r_spike      <= 1'b0;
         for (int c = 0; c < int'(N_CLASS); c++) r_acc[c] <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_image_req  <= (w_state_nxt == S_IDLE);
         r_set_up_req <= !(w_set_full_n && w_mst_full_n && w_blk_full_n);
         r_valid      <= w_valid_nxt;
         r_spike      <= w_spike_nxt;
         if (w_consume) begin
            r_wcnt <= (r_wcnt == AW'(N_WORDS - 1)) ? '0 : r_wcnt + AW'(1);
            for (int c = 0; c < int'(N_CLASS); c++)
               r_acc[c] <= w_first ? w_contrib[c] : r_acc[c] + w_contrib[c];
         end
         if (r_state == S_DECIDE) begin
            r_winner <= w_winner;
            r_k      <= '0;
         end else if (r_state == S_OUT) begin
            r_k <= r_k + KW'(1);
         end
      end
   end

   assign image_req          = r_image_req;
   assign set_up_req         = r_set_up_req;
   assign result_spike       = r_spike;
   assign result_spike_valid = r_valid;
endmodule

// File: tb/tb_sdfa_snn_top.sv
// Scoreboard bench for sdfa_snn_top: reference argmax model per image, spike-train monitor.

module tb_sdfa_snn_top;
   logic        clk, rstn;
   logic [63:0] data_in;
   logic        pixel_valid, train, set_number, set_valid;
   logic        master_inf_valid, master_in, block_inf_valid, block_in;
   logic        image_req, set_up_req, result_spike, result_spike_valid;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int cyc_last = 0;

   logic signed [3:0] wt [98][8][10];
   logic [63:0]       img [98];
   logic [7:0]        thr = 8'h80;
   int                exp_q[$];

   sdfa_snn_top dut (
      .clk(clk), .rstn(rstn), .data_in(data_in), .pixel_valid(pixel_valid), .train(train),
      .set_number(set_number), .set_valid(set_valid),
      .master_inf_valid(master_inf_valid), .master_in(master_in),
      .block_inf_valid(block_inf_valid), .block_in(block_in),
      .image_req(image_req), .set_up_req(set_up_req),
      .result_spike(result_spike), .result_spike_valid(result_spike_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int model_winner();
      int acc [10];
      int best_i;
      for (int c = 0; c < 10; c++) acc[c] = 0;
      for (int w = 0; w < 98; w++)
         for (int p = 0; p < 8; p++)
            if (img[w][8*p +: 8] >= thr)
               for (int c = 0; c < 10; c++) acc[c] += int'(wt[w][p][c]);
      best_i = 0;
      for (int c = 1; c < 10; c++) if (acc[c] > acc[best_i]) best_i = c;
      return best_i;
   endfunction

   // kind: 0 class3=+1, 1 parity classes, 2 tie 2/7 rest -1, 3 all -1, 4 random
   task automatic set_weights(input int kind);
      logic [319:0] row;
      for (int w = 0; w < 98; w++) begin
         for (int p = 0; p < 8; p++)
            for (int c = 0; c < 10; c++) begin
               case (kind)
                  0: wt[w][p][c] = (c == 3) ? 4'sd1 : 4'sd0;
                  1: wt[w][p][c] = (c == (p % 2)) ? 4'sd1 : 4'sd0;
                  2: wt[w][p][c] = (c == 2 || c == 7) ? 4'sd1 : -4'sd1;
                  3: wt[w][p][c] = -4'sd1;
                  default: wt[w][p][c] = 4'($urandom_range(0, 15));
               endcase
               row[(p*10 + c)*4 +: 4] = wt[w][p][c];
            end
         dut.u_weight_sram.r_mem[w] = row;
      end
   endtask

   // kind: 0 all 0xFF, 1 even 0x7F / odd 0x80, 2 random
   task automatic set_image(input int kind);
      for (int w = 0; w < 98; w++)
         for (int p = 0; p < 8; p++)
            case (kind)
               0: img[w][8*p +: 8] = 8'hFF;
               1: img[w][8*p +: 8] = (p % 2 == 0) ? 8'h7F : 8'h80;
               default: img[w][8*p +: 8] = 8'($urandom_range(0, 255));
            endcase
   endtask

   task automatic wait_image_req();
      int n = 0;
      @(negedge clk);
      while (!image_req && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("image_req", 32'(image_req), 32'd1);
   endtask

   task automatic send_image(input int stall_at, input bit wait_done);
      int n = 0;
      wait_image_req();
      exp_q.push_back(model_winner());
      for (int w = 0; w < 98; w++) begin
         if (w == stall_at) repeat (5) begin
            pixel_valid = 1'b0;
            @(negedge clk);
         end
         data_in     = img[w];
         pixel_valid = 1'b1;
         @(negedge clk);
      end
      pixel_valid = 1'b0;
      cyc_last    = cyc;
      if (wait_done) begin
         while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
         end
         chk("result_done", 32'(exp_q.size()), 32'd0);
      end
   endtask

   task automatic load_cfg();
      logic [11:0] sv = {4'hA, 8'h80};
      for (int i = 0; i < 255; i++) begin
         @(negedge clk);
         if (i == 11) chk("image_req_pre", 32'(image_req), 32'd0);
         if (i == 12) chk("image_req_post", 32'(image_req), 32'd1);
         if (i == 254) chk("setup_pre", 32'(set_up_req), 32'd1);
         set_valid        = (i < 12);
         set_number       = (i < 12) ? sv[i[3:0]] : 1'b0;
         block_inf_valid  = (i < 171);
         block_in         = 1'($urandom_range(0, 1));
         master_inf_valid = 1'b1;
         master_in        = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk("setup_done", 32'(set_up_req), 32'd0);
      set_valid        = 1'b0;
      block_inf_valid  = 1'b0;
      master_inf_valid = 1'b0;
   endtask

   // Collect each spike train and compare with the oldest expected winner
   int          mk = 0;
   logic [15:0] mbits = '0;
   always @(negedge clk) begin
      logic [31:0] expv;
      if (rstn) begin
         mk    = 0;
         mbits = '0;
      end else if (result_spike_valid) begin
         if (mk == 0) chk("latency", 32'(cyc - cyc_last), 32'd2);
         if (mk < 16) mbits[mk] = result_spike;
         mk++;
      end else if (mk > 0) begin
         expv = (exp_q.size() == 0) ? 32'hFFFF : 32'(1) << exp_q.pop_front();
         chk("spike_train", 32'(mbits), expv);
         chk("train_len", 32'(mk), 32'd10);
         mk    = 0;
         mbits = '0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int vcnt;
      rstn = 1'b1; data_in = '0; pixel_valid = 1'b0; train = 1'b0;
      set_number = 1'b0; set_valid = 1'b0; master_inf_valid = 1'b0; master_in = 1'b0;
      block_inf_valid = 1'b0; block_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_image_req", 32'(image_req), 32'd0);
      chk("rst_set_up_req", 32'(set_up_req), 32'd1);
      chk("rst_valid", 32'(result_spike_valid), 32'd0);
      chk("rst_spike", 32'(result_spike), 32'd0);
      rstn = 1'b0;

      load_cfg();

      set_weights(0); set_image(0); send_image(-1, 1'b1);   // winner 3
      set_weights(1); set_image(1); send_image(-1, 1'b1);   // only 0x80 count: winner 1
      set_weights(2); set_image(0); send_image(-1, 1'b1);   // tie 2/7: winner 2
      set_weights(3); set_image(0); send_image(-1, 1'b1);   // all equal: winner 0

      set_weights(4); set_image(2);
      send_image(40, 1'b0);
      send_image(-1, 1'b1);                                 // same image back-to-back
      set_image(2);
      send_image(-1, 1'b1);

      // Abort mid-image
      wait_image_req();
      for (int w = 0; w < 50; w++) begin
         data_in     = img[w];
         pixel_valid = 1'b1;
         @(negedge clk);
      end
      rstn        = 1'b1;
      pixel_valid = 1'b0;
      @(negedge clk);
      chk("abort_image_req", 32'(image_req), 32'd0);
      chk("abort_set_up_req", 32'(set_up_req), 32'd1);
      chk("abort_valid", 32'(result_spike_valid), 32'd0);
      rstn = 1'b0;
      vcnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (result_spike_valid) vcnt++;
      end
      chk("abort_no_output", 32'(vcnt), 32'd0);
      chk("abort_cfg_needed", 32'(set_up_req), 32'd1);

      load_cfg();
      set_weights(0); set_image(0); send_image(-1, 1'b1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
